cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
Multi-cycle phase controller for the 8-bit ExceptioNull CPU datapath. It latches the fetched instruction and steps the datapath through fetch, decode, register read, execute, memory access, writeback select, writeback and PC update. It drives each phase with a single-cycle strobe to the instruction memory, control unit, ALU, data memory and program counter. It replaces the free-running state counter with a clocked FSM that has reset, memory-wait, memory-skip and halt handling.

Parameters:
INSTR_W, 8, instruction width in bits; opcode is instr[INSTR_W-1:INSTR_W-4].
MEM_TIMEOUT, 15, max cycles spent in MEM waiting for mem_ready before error; range 1..255.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = start/continue execution
instr  in  INSTR_W  instruction word from instruction memory
instr_valid  in  1  instr is valid this cycle
mem_ready  in  1  data memory has completed the access
instr_q  out  INSTR_W  latched current instruction
fetch_stb  out  1  instruction memory fetch pulse
decode_stb  out  1  control unit decode pulse
regrd_stb  out  1  register file read pulse
exec_stb  out  1  ALU execute pulse
mem_stb  out  1  data memory access pulse
wbsel_stb  out  1  writeback source select pulse
wb_stb  out  1  register writeback pulse
pc_stb  out  1  program counter update pulse
state  out  4  current FSM state encoding
busy  out  1  FSM is not in IDLE or HALT
halted  out  1  FSM is in HALT
mem_err  out  1  sticky memory-timeout flag
retired_cnt  out  CNT_W  count of completed instructions

Behaviour:
- Reset: async on rst_n low. state=IDLE. All strobes 0, instr_q=0, busy=0, halted=0, mem_err=0, retired_cnt=0. Reset aborts any in-flight instruction immediately; no strobe is emitted after rst_n falls.
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, REGRD=3, EXEC=4, MEM=5, WBSEL=6, WB=7, PCUPD=8, HALT=9.
- Transitions:
  - IDLE: to FETCH when run=1.
  - FETCH: waits while instr_valid=0. When instr_valid=1, latch instr into instr_q. If instr==0, go to HALT; otherwise go to DECODE.
  - DECODE -> REGRD -> EXEC, one cycle each.
  - EXEC: go to MEM if opcode is 4'b1010 (lw) or 4'b1011 (sw); otherwise go to WBSEL, skipping MEM.
  - MEM: go to WBSEL on mem_ready. If MEM_TIMEOUT cycles elapse without mem_ready, set mem_err=1 and go to HALT. The wait counter resets on MEM entry.
  - WBSEL -> WB -> PCUPD, one cycle each.
  - PCUPD: retired_cnt+=1, wrapping modulo 2^CNT_W. Go to FETCH if run=1, else IDLE.
  - HALT: go to IDLE when run=0; mem_err persists until reset.
- Strobes:
  - Registered (Moore) outputs, high for exactly one cycle: the first cycle the FSM occupies the matching state.
  - Never high while stalled in FETCH or MEM beyond the first cycle.
  - At most one strobe is high in any cycle.
- Latency: non-memory instruction = 7 cycles with instr_valid tied 1. Memory instruction = 8 + (mem_ready delay) cycles.
- run dropping mid-instruction does not abort it; it takes effect only at PCUPD.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins, no error.
- busy=1 in states 1..8; halted=1 only in HALT.
- instr_q holds its value until the next successful fetch.

Optional Feature:
CPU_SEQ_STEP_EN. When defined, adds input step (1 bit) and state STEP_WAIT=10. PCUPD goes to STEP_WAIT instead of FETCH; STEP_WAIT goes to FETCH on a step=1 cycle, or to IDLE if run=0. When undefined, there is no step port and PCUPD behaves as above.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum with fixed encodings;
  - opcode constants OP_LW=4'b1010, OP_SW=4'b1011, OP_BEQ=4'b1100, OP_BNE=4'b1101;
  - HALT_INSTR=8'h00.
- Sub-module cpu_seq_timer: loadable down-counter for the MEM timeout; ports load, en, expired.

Test Plan:
- ALU op: reset, run=1, instr=8'h15 with instr_valid=1 -> strobes fetch, decode, regrd, exec, wbsel, wb, pc on 7 consecutive cycles; mem_stb never high; retired_cnt=1.
- lw: instr=8'hA4, mem_ready raised 3 cycles after mem_stb -> FSM holds MEM 4 cycles, then wbsel_stb; instruction takes 11 cycles; mem_err=0.
- Timeout: instr=8'hB2, mem_ready held 0 -> after 15 MEM cycles mem_err=1, halted=1, state=9. run=0 -> IDLE; mem_err remains 1.
- Halt: instr=8'h00 at fetch -> next cycle halted=1, instr_q=0, no decode_stb; retired_cnt unchanged.
- Async reset: assert rst_n=0 mid-EXEC between clock edges -> state=0, all outputs 0 immediately; after release with run=1, fetch_stb one cycle later.
- Wrap: preload via 65536 ALU instructions (or CNT_W=4 with 16 instructions) -> retired_cnt wraps to 0.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the ExceptioNull CPU phase sequencer:
// FSM state encodings, opcode constants and the halt instruction word.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_REGRD     = 4'd3,
    ST_EXEC      = 4'd4,
    ST_MEM       = 4'd5,
    ST_WBSEL     = 4'd6,
    ST_WB        = 4'd7,
    ST_PCUPD     = 4'd8,
    ST_HALT      = 4'd9,
    ST_STEP_WAIT = 4'd10
  } state_e;

  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1011;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

  localparam logic [7:0] HALT_INSTR = 8'h00;

  // Only loads and stores visit the data-memory phase.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_seq_timer.sv
// Loadable down-counter used to bound the time spent waiting for mem_ready.
// expired is high while the count sits at zero; the count stops there.
module cpu_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: load wins over decrement, saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle phase controller for the ExceptioNull CPU. Steps the datapath
// through fetch .. pc-update with one-cycle Moore strobes per phase, handles
// memory wait/timeout, halt instruction and a wrapping retired counter.
// Optional single-step mode: define CPU_SEQ_STEP_EN to add the step input
// and the STEP_WAIT state between instructions.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_W     = 8,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  input  logic               mem_ready,
`ifdef CPU_SEQ_STEP_EN
  input  logic               step,
`endif
  output logic [INSTR_W-1:0] instr_q,
  output logic               fetch_stb,
  output logic               decode_stb,
  output logic               regrd_stb,
  output logic               exec_stb,
  output logic               mem_stb,
  output logic               wbsel_stb,
  output logic               wb_stb,
  output logic               pc_stb,
  output logic [3:0]         state,
  output logic               busy,
  output logic               halted,
  output logic               mem_err,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int TMR_W = 8;

  state_e             state_d, state_q;
  logic [INSTR_W-1:0] instr_d;
  logic               mem_err_d, mem_err_q;
  logic [CNT_W-1:0]   retired_cnt_d, retired_cnt_q;
  logic [7:0]         stb_d, stb_q;
  logic               busy_q, halted_q;
  logic               tmr_load, tmr_expired;

  // Timer is reloaded on every entry to MEM and counts while FSM sits there.
  assign tmr_load = (state_d == ST_MEM) && (state_q != ST_MEM);

  cpu_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_W'(MEM_TIMEOUT - 1)),
    .en       (state_q == ST_MEM),
    .expired  (tmr_expired)
  );

  // Next-state, latch and strobe decode; strobes fire on state entry only.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    mem_err_d     = mem_err_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = (instr == INSTR_W'(HALT_INSTR)) ? ST_HALT : ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_REGRD;
      ST_REGRD:  state_d = ST_EXEC;
      ST_EXEC:   state_d = is_mem_op(instr_q[INSTR_W-1 -: 4]) ? ST_MEM : ST_WBSEL;
      ST_MEM: begin
        // mem_ready takes priority over a coincident timeout
        if (mem_ready) begin
          state_d = ST_WBSEL;
        end else if (tmr_expired) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WBSEL:  state_d = ST_WB;
      ST_WB:     state_d = ST_PCUPD;
      ST_PCUPD: begin
        retired_cnt_d = retired_cnt_q + CNT_W'(1);
`ifdef CPU_SEQ_STEP_EN
        state_d = run ? ST_STEP_WAIT : ST_IDLE;
`else
        state_d = run ? ST_FETCH : ST_IDLE;
`endif
      end
`ifdef CPU_SEQ_STEP_EN
      ST_STEP_WAIT: begin
        if (!run)      state_d = ST_IDLE;
        else if (step) state_d = ST_FETCH;
      end
`endif
      ST_HALT:   if (!run) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    stb_d = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_FETCH:  stb_d[7] = 1'b1;
        ST_DECODE: stb_d[6] = 1'b1;
        ST_REGRD:  stb_d[5] = 1'b1;
        ST_EXEC:   stb_d[4] = 1'b1;
        ST_MEM:    stb_d[3] = 1'b1;
        ST_WBSEL:  stb_d[2] = 1'b1;
        ST_WB:     stb_d[1] = 1'b1;
        ST_PCUPD:  stb_d[0] = 1'b1;
        default:   stb_d    = '0;
      endcase
    end
  end

  // FSM state plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      mem_err_q     <= 1'b0;
      retired_cnt_q <= '0;
      stb_q         <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      mem_err_q     <= mem_err_d;
      retired_cnt_q <= retired_cnt_d;
      stb_q         <= stb_d;
      busy_q        <= (state_d != ST_IDLE) && (state_d != ST_HALT);
      halted_q      <= (state_d == ST_HALT);
    end
  end

  assign state       = state_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign mem_err     = mem_err_q;
  assign retired_cnt = retired_cnt_q;
  assign {fetch_stb, decode_stb, regrd_stb, exec_stb,
          mem_stb, wbsel_stb, wb_stb, pc_stb} = stb_q;

endmodule
